gpio_bus_master: RTL
====================

GPIO_BUS_MASTER -- requirements
Module: gpio_bus_master

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1, address/data setup cycles before strobe (range 1-15).
REQ-002 SHALL have parameter STROBE_CYC, default 2, cycles srd/swr held high (range 1-15).
REQ-003 SHALL have parameter HOLD_CYC, default 1, address/data hold cycles after strobe (range 1-15).
REQ-004 SHALL have parameter POLL_MAX, default 255, maximum poll reads before timeout (range 1-65535).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port n_reset  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port cmd_valid  in  1  command offered.
REQ-008 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-009 SHALL have port cmd_op  in  2  00 read, 01 write, 10 poll, 11 illegal.
REQ-010 SHALL have port cmd_addr  in  16  peripheral register address.
REQ-011 SHALL have port cmd_wdata  in  32  write data; for poll, bits [4:0] select status bit.
REQ-012 SHALL have port rsp_valid  out  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_data  out  32  last read data (0 for write).
REQ-014 SHALL have port rsp_err  out  1  poll timeout or illegal op, valid with rsp_valid.
REQ-015 SHALL have port saddress  out  16  bus address to peripheral.
REQ-016 SHALL have ports srd / swr  out  1 each  read / write strobes, peripheral acts on rising edge.
REQ-017 SHALL have port sdata_wr  out  32  write data to peripheral sdata_in.
REQ-018 SHALL have port sdata_rd  in  32  read data from peripheral sdata_out.
REQ-019 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, SETUP, STROBE, HOLD, RESP; cmd_ready high only in IDLE.
REQ-021 SHALL latch cmd_op/cmd_addr/cmd_wdata on accept; inputs ignored until return to IDLE.
REQ-022 SHALL drive saddress (and sdata_wr for write) from first SETUP cycle through last HOLD cycle, stable throughout.
REQ-023 SHALL keep srd/swr low in SETUP/HOLD, raise exactly one (srd for read/poll, swr for write) for STROBE_CYC cycles; never both high.
REQ-024 SHALL sample sdata_rd on the clock edge ending the last STROBE cycle.
REQ-025 SHALL assert rsp_valid exactly SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles after accept edge (defaults: 5), then return to IDLE; cmd_ready high the following cycle.
REQ-026 SHALL, for poll, repeat SETUP-STROBE-HOLD at same address until sampled bit cmd_wdata[4:0] is 1 (respond, rsp_err=0) or POLL_MAX reads done without it (respond with last data, rsp_err=1).
REQ-027 SHALL respond to poll success on the POLL_MAX-th read with rsp_err=0 (success wins over timeout).
REQ-028 SHALL, for op 11, skip the bus cycle: RESP the cycle after accept, rsp_err=1, rsp_data=0, no strobe.
REQ-029 SHALL drive saddress/sdata_wr to 0 in IDLE; rsp_data/rsp_err hold until the next response.
REQ-030 SHALL use a poll counter wide enough for POLL_MAX without wrap.

Reset
REQ-031 SHALL, on the edge n_reset is sampled low, enter IDLE: srd=0, swr=0, saddress=0, sdata_wr=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, counters 0.
REQ-032 SHALL hold cmd_ready low while n_reset low; high the first cycle after release.
REQ-033 SHALL abort any transaction on reset without issuing rsp_valid; strobe falls the cycle after reset sampled.

Structure
REQ-034 SHALL take opcode constants, state encoding, register addresses 16'h1094/16'h1098/16'h109c and status bit index 3 from shared package gpio_bus_pkg.
REQ-035 SHALL place phase counting (SETUP/STROBE/HOLD countdown) in sub-module gpio_bus_timer.

Verification
REQ-036 Write 0x1094 data 0x000001E0, defaults -> swr high cycles 2-3 after accept, saddress/sdata_wr stable cycles 1-4, rsp_valid cycle 5, rsp_err=0.
REQ-037 Read 0x1098 with sdata_rd=0x00000780 -> rsp_data=0x00000780 at cycle 5, swr never high.
REQ-038 Poll 0x109c bit 3, peripheral sets bit 3 on 3rd read -> exactly 3 srd pulses, rsp_err=0, rsp_data bit3=1.
REQ-039 Poll with POLL_MAX=4, bit never set -> 4 srd pulses, rsp_err=1; repeat with bit set on 4th read -> rsp_err=0.
REQ-040 Op 11 -> rsp_valid cycle after accept, rsp_err=1, no strobe; reset asserted mid-STROBE -> strobe low next cycle, no rsp_valid, cmd_ready high after release.

Source files
------------

// File: rtl/gpio_bus_pkg.sv
// ============================================================================
// Module      : gpio_bus_pkg
// Description : Shared opcodes, FSM encoding and register map for the GPIO
//               peripheral bus master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_bus_pkg;

   typedef enum logic [1:0] {
      OP_READ    = 2'b00,
      OP_WRITE   = 2'b01,
      OP_POLL    = 2'b10,
      OP_ILLEGAL = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   // Peripheral register map and the ready/done flag inside the status word
   localparam logic [15:0] c_addr_data   = 16'h1094;
   localparam logic [15:0] c_addr_dir    = 16'h1098;
   localparam logic [15:0] c_addr_status = 16'h109c;
   localparam int          c_status_bit  = 3;

   function automatic logic is_bus_phase(input state_t s);
      return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
   endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_bus_timer.sv
// ============================================================================
// Module      : gpio_bus_timer
// Description : Countdown for the SETUP/STROBE/HOLD phases of one bus cycle;
//               o_last flags the final cycle of the current phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_bus_timer
   import gpio_bus_pkg::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic   clk,
   input  logic   n_reset,
   input  logic   i_load,
   input  state_t i_phase,
   output logic   o_last
);

   logic [3:0] r_cnt;
   logic [3:0] w_load_val;

   // Loaded with length-1 so that a count of zero marks the phase's last cycle
   always_comb begin
      w_load_val = 4'd0;
      case (i_phase)
         ST_SETUP:  w_load_val = 4'(SETUP_CYC - 1);
         ST_STROBE: w_load_val = 4'(STROBE_CYC - 1);
         ST_HOLD:   w_load_val = 4'(HOLD_CYC - 1);
         default:   w_load_val = 4'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_cnt <= 4'd0;
      end else if (i_load) begin
         r_cnt <= w_load_val;
      end else if (r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   assign o_last = (r_cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/gpio_bus_master.sv
// ============================================================================
// Module      : gpio_bus_master
// Description : Turns read/write/poll commands into timed srd/swr strobe
//               cycles on a simple peripheral register bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_bus_master
   import gpio_bus_pkg::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1,
   parameter int POLL_MAX   = 255
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] sdata_wr,
   input  logic [31:0] sdata_rd,
   output logic        busy
);

   localparam int c_pcw = $clog2(POLL_MAX + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   op_t                r_op;
   logic [15:0]        r_addr;
   logic [31:0]        r_wdata;
   logic [31:0]        r_rd_data;
   logic [c_pcw-1:0]   r_poll_cnt;
   logic [31:0]        r_rsp_data;
   logic               r_rsp_err;

   logic               w_accept;
   logic               w_last;
   logic               w_tmr_load;
   logic               w_capture;
   logic               w_hit;
   logic               w_timeout;
   logic               w_in_bus;
   logic               w_rsp_load;
   logic [31:0]        w_rsp_data_nxt;
   logic               w_rsp_err_nxt;

   assign cmd_ready = (r_state == ST_IDLE) && n_reset;
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_in_bus  = is_bus_phase(r_state);
   assign w_capture = (r_state == ST_STROBE) && w_last && (r_op != OP_WRITE);
   assign w_hit     = r_rd_data[r_wdata[4:0]];
   assign w_timeout = (r_poll_cnt == c_pcw'(POLL_MAX));

   gpio_bus_timer #(
      .SETUP_CYC  (SETUP_CYC),
      .STROBE_CYC (STROBE_CYC),
      .HOLD_CYC   (HOLD_CYC)
   ) u_timer (
      .clk     (clk),
      .n_reset (n_reset),
      .i_load  (w_tmr_load),
      .i_phase (w_state_nxt),
      .o_last  (w_last)
   );

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus the response word that is committed on entry to RESP
   always_comb begin
      w_state_nxt    = r_state;
      w_rsp_load     = 1'b0;
      w_rsp_data_nxt = 32'd0;
      w_rsp_err_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (op_t'(cmd_op) == OP_ILLEGAL) begin
                  w_state_nxt   = ST_RESP;
                  w_rsp_load    = 1'b1;
                  w_rsp_err_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            if (w_last) w_state_nxt = ST_STROBE;
         end
         ST_STROBE: begin
            if (w_last) w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (w_last) begin
               if ((r_op == OP_POLL) && !w_hit && !w_timeout) begin
                  w_state_nxt = ST_SETUP;
               end else begin
                  w_state_nxt    = ST_RESP;
                  w_rsp_load     = 1'b1;
                  w_rsp_data_nxt = (r_op == OP_WRITE) ? 32'd0 : r_rd_data;
                  w_rsp_err_nxt  = (r_op == OP_POLL) && !w_hit;
               end
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_tmr_load = (w_state_nxt != r_state) && is_bus_phase(w_state_nxt);

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_op       <= OP_READ;
         r_addr     <= 16'd0;
         r_wdata    <= 32'd0;
         r_rd_data  <= 32'd0;
         r_poll_cnt <= '0;
         r_rsp_data <= 32'd0;
         r_rsp_err  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op       <= op_t'(cmd_op);
            r_addr     <= cmd_addr;
            r_wdata    <= cmd_wdata;
            r_poll_cnt <= '0;
         end
         if (w_capture) begin
            r_rd_data <= sdata_rd;
            if (r_op == OP_POLL) r_poll_cnt <= r_poll_cnt + 1'b1;
         end
         if (w_rsp_load) begin
            r_rsp_data <= w_rsp_data_nxt;
            r_rsp_err  <= w_rsp_err_nxt;
         end
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign srd       = (r_state == ST_STROBE) && (r_op != OP_WRITE);
   assign swr       = (r_state == ST_STROBE) && (r_op == OP_WRITE);
   assign saddress  = w_in_bus ? r_addr : 16'd0;
   assign sdata_wr  = (w_in_bus && (r_op == OP_WRITE)) ? r_wdata : 32'd0;

endmodule

`default_nettype wire
